// File: rtl/alu_mdu_if.sv
// Request/result bundle between the pipeline control and the alu_mdu unit.
// The master drives the request side; the slave (the unit) drives results.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  s, hi, z, busy, done, dz
    );

    modport slave (
        input  start, op, a, b,
        output s, hi, z, busy, done, dz
    );
endinterface

// File: rtl/alu_mdu.sv
// Registered execution unit: single-cycle ALU ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), one bit per clock in RUN.
// Working registers are kept apart from s/hi so partial results never show.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clock,
    input  logic       resetn,
    alu_mdu_if.slave   bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;   // accumulator / partial remainder
    logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;   // multiplier bits / dividend->quotient
    logic [WIDTH-1:0] opb_q, opb_d;         // multiplicand / divisor
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             z_q, z_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0]        alu_res;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] b_signed;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_trial;
    logic [WIDTH:0]          div_diff;
    logic [WIDTH-1:0]        step_hi;
    logic [WIDTH-1:0]        step_lo;

    // Single-cycle ALU result from the live operands (used only at acceptance).
    always_comb begin
        alu_res  = '0;
        shamt    = bus.a[SHW-1:0];
        b_signed = bus.b;
        casez (bus.op[3:0])
            4'b?000: alu_res = bus.a + bus.b;
            4'b?100: alu_res = bus.a - bus.b;
            4'b?001: alu_res = bus.a & bus.b;
            4'b?101: alu_res = bus.a | bus.b;
            4'b?010: alu_res = bus.a ^ bus.b;
            4'b?110: alu_res = bus.b << 16;
            4'b0011: alu_res = bus.b << shamt;
            4'b0111: alu_res = bus.b >> shamt;
            4'b1111: alu_res = $unsigned(b_signed >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration step of multiply (shift-add) or divide (restoring).
    always_comb begin
        mul_sum   = {1'b0, wrk_hi_q} + {1'b0, (wrk_lo_q[0] ? opb_q : '0)};
        div_trial = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        step_hi   = wrk_hi_q;
        step_lo   = wrk_lo_q;
        if (is_div_q) begin
            // Borrow out (top bit set) means the trial subtraction failed: restore.
            if (div_diff[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {wrk_lo_q[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {wrk_lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Shift the carry-extended sum right into the multiplier register.
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
        end
    end

    // Next-state and result logic for the IDLE/RUN controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        wrk_hi_d = wrk_hi_q;
        wrk_lo_d = wrk_lo_q;
        opb_d    = opb_q;
        s_d      = s_q;
        hi_d     = hi_q;
        z_d      = z_q;
        done_d   = 1'b0;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dz_d = 1'b0;
                    if (!bus.op[4]) begin
                        s_d    = alu_res;
                        z_d    = (alu_res == '0);
                        done_d = 1'b1;
                    end else if (bus.op[3:0] == 4'b0000 ||
                                 (bus.op[3:0] == 4'b0001 && bus.b != '0)) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = bus.op[0];
                        wrk_hi_d = '0;
                        wrk_lo_d = bus.a;
                        opb_d    = bus.b;
                    end else if (bus.op[3:0] == 4'b0001) begin
                        // Zero divisor: flag it and finish immediately.
                        s_d    = '1;
                        hi_d   = bus.a;
                        z_d    = 1'b0;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        s_d    = '0;
                        hi_d   = '0;
                        z_d    = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                wrk_hi_d = step_hi;
                wrk_lo_d = step_lo;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    s_d     = step_lo;
                    hi_d    = step_hi;
                    z_d     = (step_lo == '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            wrk_hi_q <= '0;
            wrk_lo_q <= '0;
            opb_q    <= '0;
            s_q      <= '0;
            hi_q     <= '0;
            z_q      <= 1'b1;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            wrk_hi_q <= wrk_hi_d;
            wrk_lo_q <= wrk_lo_d;
            opb_q    <= opb_d;
            s_q      <= s_d;
            hi_q     <= hi_d;
            z_q      <= z_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.hi   = hi_q;
    assign bus.z    = z_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu (WIDTH=32) with hand-computed results.
module tb_alu_mdu;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_LUI  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01111;
    localparam logic [4:0] OP_BAD  = 5'b01011;
    localparam logic [4:0] OP_MULU = 5'b10000;
    localparam logic [4:0] OP_DIVU = 5'b10001;
    localparam logic [4:0] OP_XMD  = 5'b10010;

    logic clock;
    logic resetn;
    int   errors;
    int   checks;

    alu_mdu_if #(.WIDTH(WIDTH)) bus ();

    alu_mdu #(.WIDTH(WIDTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for done; returns latency in edges and busy cycles.
    // Optionally pulses a spurious start mid-run to show it is ignored.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        lat       = 0;
        busy_cnt  = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
            bus.start = inject && (lat == 5);
            if (inject && lat == 5) begin
                bus.op = OP_ADD;
                bus.a  = 32'd1;
                bus.b  = 32'd1;
            end
        end while (!bus.done && lat < 100);
        bus.start = 1'b0;
        if (!bus.done) check("timeout", 64'(bus.done), 64'd1);
        $display("op=%b a=%h b=%h -> s=%h hi=%h z=%b dz=%b lat=%0d busy=%0d",
                 op, a, b, bus.s, bus.hi, bus.z, bus.dz, lat, busy_cnt);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_s;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int bcnt;
        errors    = 0;
        checks    = 0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_s",    64'(bus.s),    64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_z",    64'(bus.z),    64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz",   64'(bus.dz),   64'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // ADD with wrap into the sign bit, then SUB to zero
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, lat, bcnt);
        check("add_lat", 64'(lat), 64'd1);
        check("add_s",   64'(bus.s), 64'h8000_0000);
        check("add_z",   64'(bus.z), 64'd0);
        @(posedge clock);
        #1;
        check("done_drop", 64'(bus.done), 64'd0);
        run_op(OP_SUB, 32'd5, 32'd5, 1'b0, lat, bcnt);
        check("sub_s",  64'(bus.s),  64'd0);
        check("sub_z",  64'(bus.z),  64'd1);
        check("sub_hi", 64'(bus.hi), 64'd0);

        // Single-cycle vector table
        vecs.push_back('{OP_SRA, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000});
        vecs.push_back('{OP_SRL, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000});
        vecs.push_back('{OP_SLL, 32'd31,        32'd1,         32'h8000_0000});
        vecs.push_back('{OP_SLL, 32'hFFFF_FFE1, 32'h0000_0003, 32'h0000_0006});
        vecs.push_back('{OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200});
        vecs.push_back('{OP_OR,  32'hF0F0_0000, 32'h0F00_00FF, 32'hFFF0_00FF});
        vecs.push_back('{OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
        vecs.push_back('{OP_LUI, 32'h1234_5678, 32'h0000_ABCD, 32'hABCD_0000});
        vecs.push_back('{OP_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF});
        vecs.push_back('{OP_BAD, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
            check($sformatf("vec%0d_s", i), 64'(bus.s), 64'(vecs[i].exp_s));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
        end

        // MULU max*max with an ignored start mid-run
        run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bcnt);
        check("mul_lat",  64'(lat),  64'd33);
        check("mul_busy", 64'(bcnt), 64'd32);
        check("mul_prod", {bus.hi, bus.s}, 64'hFFFF_FFFE_0000_0001);
        check("mul_z",    64'(bus.z), 64'd0);
        @(posedge clock);
        #1;
        check("mul_done_drop", 64'(bus.done), 64'd0);
        check("mul_idle",      64'(bus.busy), 64'd0);

        // Single-cycle op leaves hi alone
        run_op(OP_ADD, 32'd10, 32'd20, 1'b0, lat, bcnt);
        check("add_s2",     64'(bus.s),  64'd30);
        check("add_hi_keep", 64'(bus.hi), 64'hFFFF_FFFE);

        // DIVU normal and zero divisor
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bcnt);
        check("div_lat", 64'(lat), 64'd33);
        check("div_qr",  {bus.hi, bus.s}, {32'd2, 32'd14});
        check("div_dz",  64'(bus.dz), 64'd0);
        run_op(OP_DIVU, 32'd9, 32'd0, 1'b0, lat, bcnt);
        check("dz_lat",  64'(lat),  64'd1);
        check("dz_busy", 64'(bcnt), 64'd0);
        check("dz_qr",   {bus.hi, bus.s}, {32'd9, 32'hFFFF_FFFF});
        check("dz_flag", 64'(bus.dz), 64'd1);
        @(posedge clock);
        #1;
        check("dz_hold", 64'(bus.dz), 64'd1);
        run_op(OP_XMD, 32'd3, 32'd4, 1'b0, lat, bcnt);
        check("xmd_qr",  {bus.hi, bus.s}, 64'd0);
        check("xmd_z",   64'(bus.z), 64'd1);
        check("dz_clr",  64'(bus.dz), 64'd0);

        // Reset in the middle of a MULU
        bus.start = 1'b1;
        bus.op    = OP_MULU;
        bus.a     = 32'd123;
        bus.b     = 32'd456;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        resetn = 1'b0;
        #1;
        check("ar_s",    64'(bus.s),    64'd0);
        check("ar_hi",   64'(bus.hi),   64'd0);
        check("ar_z",    64'(bus.z),    64'd1);
        check("ar_busy", 64'(bus.busy), 64'd0);
        check("ar_dz",   64'(bus.dz),   64'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1;
            check("ar_no_done", 64'(bus.done), 64'd0);
        end
        run_op(OP_ADD, 32'd2, 32'd3, 1'b0, lat, bcnt);
        check("ar_add", 64'(bus.s), 64'd5);

        // Back-to-back: DIVU issued in the done cycle of a MULU
        run_op(OP_MULU, 32'd3, 32'd4, 1'b0, lat, bcnt);
        check("b2b_mul", {bus.hi, bus.s}, 64'd12);
        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, lat, bcnt);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_div", {bus.hi, bus.s}, {32'd1, 32'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
